// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port (CPU / debug) arbiter for a single-port data memory with
//            starvation override; optional round-robin via DMEM_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                CNT_W        = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  C_STARVE_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0]  C_CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;
  logic             w_d_win;

  assign w_starved = (r_starve_cnt == C_STARVE_MAX);

`ifdef DMEM_ARB_RR_EN
  // 1 = port D won the most recent granted cycle; resets to C.
  logic r_last_d;

  assign w_d_win = d_req & (~c_req | w_starved | ~r_last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if (c_gnt | d_gnt) begin
      r_last_d <= d_gnt;
    end
  end
`else
  assign w_d_win = d_req & (~c_req | w_starved);
`endif

  assign d_gnt   = w_d_win;
  assign c_gnt   = c_req & ~w_d_win;
  assign c_stall = c_req & ~c_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (c_gnt) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Counts consecutive denied cycles of a live D request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (d_req & ~d_gnt) begin
      if (!w_starved) begin
        r_starve_cnt <= r_starve_cnt + C_CNT_ONE;
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= c_gnt & ~c_we;
      d_rvalid <= d_gnt & ~d_we;
      if (c_gnt & ~c_we) begin
        c_rdata <= mem_rdata;
      end
      if (d_gnt & ~d_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Scoreboard bench for dmem_arbiter; honours DMEM_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              c_req = 1'b0, c_we = 1'b0;
  logic [ADDR_W-1:0] c_addr = '0;
  logic [DATA_W-1:0] c_wdata = '0;
  logic              d_req = 1'b0, d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid, mem_we;
  logic [DATA_W-1:0] c_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic preload = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Physical word memory driven by the DUT; index by word within the byte address.
  logic [31:0] mem [16];
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'(i + 1);
    end else if (mem_we) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t cq[$];
  rsp_t dq[$];

  // Reference model: what memory should contain and who should win each cycle.
  logic [31:0] ref_mem [16];
  int          denied = 0;
  bit          last_was_d = 1'b0;
  bit          exp_c, exp_d;

  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'(i + 1);
    end else if (!rst_n) begin
      denied     = 0;
      last_was_d = 1'b0;
    end else begin
      if (c_req && d_req) begin
`ifdef DMEM_ARB_RR_EN
        exp_d = (denied >= STARVE_MAX) || !last_was_d;
`else
        exp_d = (denied >= STARVE_MAX);
`endif
        exp_c = !exp_d;
      end else begin
        exp_c = c_req;
        exp_d = d_req;
      end
      chk("c_gnt", 32'(c_gnt), 32'(exp_c));
      chk("d_gnt", 32'(d_gnt), 32'(exp_d));
      chk("c_stall", 32'(c_stall), 32'(c_req && !exp_c));
      chk("mem_we", 32'(mem_we), exp_c ? 32'(c_we) : exp_d ? 32'(d_we) : 32'd0);
      chk("mem_addr", 32'(mem_addr), exp_c ? 32'(c_addr) : exp_d ? 32'(d_addr) : 32'd0);
      chk("mem_wdata", mem_wdata, exp_c ? c_wdata : exp_d ? d_wdata : 32'd0);
      if (exp_c) begin
        last_was_d = 1'b0;
        if (c_we) ref_mem[c_addr[5:2]] = c_wdata;
        else      cq.push_back('{cyc + 1, ref_mem[c_addr[5:2]]});
      end else if (exp_d) begin
        last_was_d = 1'b1;
        if (d_we) ref_mem[d_addr[5:2]] = d_wdata;
        else      dq.push_back('{cyc + 1, ref_mem[d_addr[5:2]]});
      end
      denied = (d_req && !exp_d) ? denied + 1 : 0;
    end
  end

  // Response monitor: pulses must appear exactly when due, data must hold otherwise.
  logic [31:0] exp_crd = '0, exp_drd = '0;
  bit          g_c = 1'b0, g_d = 1'b0;
  rsp_t        r;

  always @(negedge clk) begin
    g_c = c_gnt;
    g_d = d_gnt;
    if (!rst_n) begin
      cq.delete();
      dq.delete();
      exp_crd = '0;
      exp_drd = '0;
      chk("c_rvalid_rst", 32'(c_rvalid), 32'd0);
      chk("d_rvalid_rst", 32'(d_rvalid), 32'd0);
    end else begin
      if (cq.size() != 0 && cq[0].due == cyc) begin
        r = cq.pop_front();
        exp_crd = r.data;
        chk("c_rvalid", 32'(c_rvalid), 32'd1);
      end else begin
        chk("c_rvalid", 32'(c_rvalid), 32'd0);
      end
      if (dq.size() != 0 && dq[0].due == cyc) begin
        r = dq.pop_front();
        exp_drd = r.data;
        chk("d_rvalid", 32'(d_rvalid), 32'd1);
      end else begin
        chk("d_rvalid", 32'(d_rvalid), 32'd0);
      end
    end
    chk("c_rdata", c_rdata, exp_crd);
    chk("d_rdata", d_rdata, exp_drd);
  end

  // Issue one request on a port and hold it until granted (bounded).
  task automatic access(input bit pd, input bit we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd);
    bit ok = 1'b0;
    if (pd) begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
    else    begin c_req = 1'b1; c_we = we; c_addr = a; c_wdata = wd; end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pd ? d_gnt : c_gnt) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout port=%0d got no grant expected grant within 50 cycles", pd);
    end
    @(posedge clk); #1;
    if (pd) d_req = 1'b0; else c_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(2);
    preload = 1'b0;
    rst_n   = 1'b1;
    idle(1);

    // D back-to-back reads of preloaded words 1 and 2.
    access(1'b1, 1'b0, 6'h00, '0);
    access(1'b1, 1'b0, 6'h04, '0);
    idle(2);

    // C write then read-back two cycles later.
    access(1'b0, 1'b1, 6'h08, 32'hDEADBEEF);
    idle(1);
    access(1'b0, 1'b0, 6'h08, '0);
    idle(2);

    // D gives up while C holds priority; no side effects expected.
    fork
      begin repeat (4) access(1'b0, 1'b1, 6'h10, $urandom); end
      begin
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'h20; d_wdata = 32'h5A5A5A5A;
        repeat (2) begin @(posedge clk); #1; end
        d_req = 1'b0;
      end
    join
    idle(1);

    // Continuous contention exposes the starvation/round-robin pattern.
    fork
      begin for (int i = 0; i < 10; i++) access(1'b0, 1'b0, 6'(4 * (i % 16)), '0); end
      begin for (int i = 0; i < 3; i++) access(1'b1, 1'b0, 6'(4 * i), '0); end
    join
    idle(2);

    // Reset lands mid-cycle while a read is granted and a prior read is returning.
    access(1'b0, 1'b0, 6'h08, '0);
    c_req = 1'b1; c_we = 1'b0; c_addr = 6'h04;
    @(negedge clk); #2;
    rst_n = 1'b0;
    c_req = 1'b0;
    #1;
    chk("async_rst_c_rvalid", 32'(c_rvalid), 32'd0);
    chk("async_rst_c_rdata", c_rdata, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Randomised traffic with occasional cancellations.
    repeat (400) begin
      if (c_req && !g_c) begin
        if ($urandom_range(7) == 0) c_req = 1'b0;
      end else begin
        c_req = ($urandom_range(3) != 0); c_we = 1'($urandom);
        c_addr = 6'($urandom); c_wdata = $urandom;
      end
      if (d_req && !g_d) begin
        if ($urandom_range(7) == 0) d_req = 1'b0;
      end else begin
        d_req = ($urandom_range(2) == 0); d_we = 1'($urandom);
        d_addr = 6'($urandom); d_wdata = $urandom;
      end
      idle(1);
    end
    c_req = 1'b0;
    d_req = 1'b0;
    idle(4);
    chk("c_pending_rsp", 32'(cq.size()), 32'd0);
    chk("d_pending_rsp", 32'(dq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU MEM stage (port C) and a debug/loader port (port D).
- Grants at most one access per cycle and drives the memory's address, write-enable and write-data inputs.
- Registers read data and returns it to the winning requester one cycle after the grant.
- Stalls the CPU whenever it loses arbitration; a starvation counter keeps port D from being locked out indefinitely.

Parameters:
- ADDR_W, 6: byte-address width; matches the data memory's address port.
- DATA_W, 32: data word width.
- STARVE_MAX, 4: number of consecutive cycles port D may be denied while requesting before it is forced to win.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- c_req  in  1  CPU access request; held until c_gnt.
- c_we  in  1  CPU write (1) / read (0).
- c_addr  in  ADDR_W  CPU byte address.
- c_wdata  in  DATA_W  CPU write data.
- c_gnt  out  1  CPU access performed this cycle (combinational).
- c_stall  out  1  c_req & ~c_gnt; drives the pipeline stall.
- c_rvalid  out  1  CPU read data valid (registered).
- c_rdata  out  DATA_W  CPU read data (registered).
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same as the port C signals, for port D; there is no d_stall.
- mem_addr  out  ADDR_W  to the data memory address input.
- mem_we  out  1  to the data memory write-enable.
- mem_wdata  out  DATA_W  to the data memory write data.
- mem_rdata  in  DATA_W  combinational read data from the data memory.

Behaviour:
- Grant decision is combinational from the current requests and registered state. Exactly one grant or none; c_gnt & d_gnt is never 1.
- Default fixed priority: C wins when both request. Exception: when starve_cnt == STARVE_MAX and d_req=1, D wins.
- starve_cnt, an internal register of width clog2(STARVE_MAX+1):
  - increments when d_req & ~d_gnt;
  - clears when d_gnt or when ~d_req;
  - saturates at STARVE_MAX.
- Memory mux:
  - Granted port drives mem_addr, mem_wdata and mem_we = that port's we.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Writes complete at the posedge ending the grant cycle. No response pulse is generated for writes.
- Reads, latency 1: in the grant cycle, mem_rdata is captured. On the next cycle x_rvalid=1 for one cycle and x_rdata holds the word.
- x_rdata holds its value until the next read completes on that port.
- x_rvalid is high for exactly one cycle per granted read and never for writes.
- Back-to-back grants to the same port produce back-to-back rvalid pulses.
- Read-after-write to the same address on consecutive grants returns the new data.
- Requests are level-held. A requester may change addr/we/wdata only after receiving a grant. Deasserting req without a grant cancels the request with no side effects.
- Address passes through unchanged. Word selection and misalignment handling belong to the memory.
- Reset (asynchronous, any time):
  - c_rvalid=d_rvalid=0, c_rdata=d_rdata=0, starve_cnt=0 (last-winner register, when present, resets to C).
  - A read granted in the cycle reset asserts produces no rvalid.
  - Combinational outputs follow the inputs during reset. Memory writes are not suppressed by the arbiter during reset; the team requires requesters to hold req=0 while rst_n=0.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined:
  - Round-robin replaces fixed priority. A last-winner register (1 bit, reset to C) records the previous winner.
  - On contention, the port that did not win last time wins.
  - starve_cnt still exists but never reaches STARVE_MAX under contention.
- Undefined: fixed C priority with starvation override as described under Behaviour.

Test Plan:
- C writes 0xDEADBEEF to address 0x08; two cycles later C reads 0x08 -> c_gnt=1 in both request cycles, c_stall=0, c_rvalid pulses one cycle after the read grant with c_rdata=0xDEADBEEF, d_rvalid stays 0.
- C and D request continuously with STARVE_MAX=4 and DMEM_ARB_RR_EN undefined -> C granted 4 cycles, D granted on the 5th with c_stall=1 that cycle, then the pattern repeats.
- Same stimulus with DMEM_ARB_RR_EN defined -> grants alternate C, D, C, D starting with D (last winner is C after reset).
- D reads 0x00 and 0x04 on consecutive cycles after memory is preloaded with 1 and 2 -> d_rvalid high two consecutive cycles, d_rdata=1 then 2.
- C read granted, rst_n pulled low mid-cycle before the next posedge -> c_rvalid=0 and c_rdata=0 immediately; no rvalid after release; starve_cnt=0.
- D requests, then drops d_req before being granted while C holds priority -> no memory write occurs, starve_cnt returns to 0, d_rvalid never asserts.
